hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage core. It drives the write-enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use stalls, taken-branch flushes and data-memory wait freezes, and it counts stall, flush and freeze cycles for debug. A watchdog flags memory waits that exceed a bound.

---
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_ctrl.sv | 100 ++++++++++
 tb/tb_hazard_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The master side drives the hazard inputs; the slave side is the controller.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             mem_busy;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] freeze_cnt;
    logic             mem_timeout;
    logic             state;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_busy,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
               mem_wb_flush, stall_cnt, flush_cnt, freeze_cnt, mem_timeout, state
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_busy,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
               mem_wb_flush, stall_cnt, flush_cnt, freeze_cnt, mem_timeout, state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, branch flush, memory freeze,
// debug counters and a sticky watchdog on long memory waits.
//
// state  | meaning
// RUN    | last edge saw mem_busy = 0
// FREEZE | last edge saw mem_busy = 1 (pipeline held)
module hazard_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);
    localparam int              FL_W   = $clog2(TIMEOUT + 1);
    localparam logic [FL_W-1:0] FL_MAX = FL_W'(TIMEOUT);
    localparam logic [FL_W-1:0] FL_ONE = FL_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {RUN = 1'b0, FREEZE = 1'b1} state_t;

    state_t           r_state;
    logic [FL_W-1:0]  r_freeze_len;
    logic             r_mem_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_freeze_cnt;

    logic w_load_use;
    logic w_freeze;
    logic w_branch;
    logic w_stall;

    assign w_load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                        ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                         (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
    assign w_freeze   = hz.mem_busy;
    assign w_branch   = hz.ex_branch_taken && !w_freeze;
    assign w_stall    = w_load_use && !hz.ex_branch_taken && !w_freeze;

    // Controls are purely combinational from current inputs; reset forces normal flow.
    always_comb begin
        hz.pc_en        = 1'b1;
        hz.if_id_en     = 1'b1;
        hz.id_ex_en     = 1'b1;
        hz.ex_mem_en    = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_flush  = 1'b0;
        hz.mem_wb_flush = 1'b0;
        if (!reset) begin
            if (w_freeze) begin
                hz.pc_en        = 1'b0;
                hz.if_id_en     = 1'b0;
                hz.id_ex_en     = 1'b0;
                hz.ex_mem_en    = 1'b0;
                hz.mem_wb_flush = 1'b1;
            end else if (w_branch) begin
                hz.if_id_flush  = 1'b1;
                hz.id_ex_flush  = 1'b1;
            end else if (w_stall) begin
                hz.pc_en        = 1'b0;
                hz.if_id_en     = 1'b0;
                hz.id_ex_flush  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_freeze_len  <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_freeze_cnt  <= '0;
        end else begin
            r_state <= w_freeze ? FREEZE : RUN;
            if (w_freeze) begin
                if (r_freeze_len != FL_MAX)
                    r_freeze_len <= r_freeze_len + FL_ONE;
                // Trips on the edge where the length reaches TIMEOUT.
                if (r_freeze_len >= FL_MAX - FL_ONE)
                    r_mem_timeout <= 1'b1;
                r_freeze_cnt <= r_freeze_cnt + CNT_ONE;
            end else begin
                r_freeze_len <= '0;
            end
            if (w_stall)
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (w_branch)
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign hz.state       = r_state;
    assign hz.mem_timeout = r_mem_timeout;
    assign hz.stall_cnt   = r_stall_cnt;
    assign hz.flush_cnt   = r_flush_cnt;
    assign hz.freeze_cnt  = r_freeze_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver applies directed vectors and queues
// expected responses; a negedge monitor pops and compares them.
module tb_hazard_ctrl;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush}
    localparam logic [6:0] NRM = 7'b1111000;
    localparam logic [6:0] FRZ = 7'b0000001;
    localparam logic [6:0] BRF = 7'b1111110;
    localparam logic [6:0] LUS = 7'b0011010;

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       busy;
        logic [6:0] ctrl;
    } vec_t;

    typedef struct {
        logic [6:0] ctrl;
        logic [3:0] stall;
        logic [3:0] flush;
        logic [3:0] freeze;
        logic       st;
        logic       to;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic v(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd, input logic mr,
                     input logic br, input logic busy, input logic [6:0] ctrl);
        vec_t t;
        t.rst = rst; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2;
        t.rd = rd; t.mr = mr; t.br = br; t.busy = busy; t.ctrl = ctrl;
        vecs.push_back(t);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) v(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("ctrl", {25'd0, hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en,
                         hz.if_id_flush, hz.id_ex_flush, hz.mem_wb_flush}, {25'd0, e.ctrl});
            chk("stall_cnt",   {28'd0, hz.stall_cnt},  {28'd0, e.stall});
            chk("flush_cnt",   {28'd0, hz.flush_cnt},  {28'd0, e.flush});
            chk("freeze_cnt",  {28'd0, hz.freeze_cnt}, {28'd0, e.freeze});
            chk("state",       {31'd0, hz.state},       {31'd0, e.st});
            chk("mem_timeout", {31'd0, hz.mem_timeout}, {31'd0, e.to});
        end
    end

    initial begin
        int   m_stall, m_flush, m_freeze, m_len;
        logic m_st, m_to;
        exp_t e;
        m_stall = 0; m_flush = 0; m_freeze = 0; m_len = 0; m_st = 0; m_to = 0;

        reset = 1'b1;
        hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
        hz.ex_rd = '0; hz.ex_mem_read = 0; hz.ex_branch_taken = 0; hz.mem_busy = 0;

        // Reset forces normal controls even with hazards present
        v(1, 5, 5, 1, 1, 5, 1, 1, 1, NRM);
        v(1, 5, 5, 1, 1, 5, 1, 0, 0, NRM);
        idle(2);
        // Load-use on rs2, then ex_rd = 0, then unused rs1 match, then used rs1 match
        v(0, 0, 5, 0, 1, 5, 1, 0, 0, LUS);
        idle(1);
        v(0, 0, 0, 0, 1, 0, 1, 0, 0, NRM);
        v(0, 7, 0, 0, 0, 7, 1, 0, 0, NRM);
        v(0, 7, 0, 1, 0, 7, 0, 0, 0, NRM);
        v(0, 7, 0, 1, 0, 7, 1, 0, 0, LUS);
        // Branch together with load-use: branch wins
        v(0, 0, 5, 0, 1, 5, 1, 1, 0, BRF);
        idle(1);
        // Busy with branch held for 3 cycles, then branch releases
        v(0, 0, 0, 0, 0, 0, 0, 1, 1, FRZ);
        v(0, 0, 0, 0, 0, 0, 0, 1, 1, FRZ);
        v(0, 0, 0, 0, 0, 0, 0, 1, 1, FRZ);
        v(0, 0, 0, 0, 0, 0, 0, 1, 0, BRF);
        idle(2);
        // Watchdog: 4 consecutive busy edges trips, sticky afterwards
        for (int i = 0; i < 4; i++) v(0, 3, 3, 1, 1, 3, 1, 0, 1, FRZ);
        idle(3);
        // Wrap: 17 load-use cycles after reset
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, NRM);
        for (int i = 0; i < 17; i++) v(0, 9, 0, 1, 0, 9, 1, 0, 0, LUS);
        idle(1);
        // Reset in the middle of a freeze
        v(0, 0, 0, 0, 0, 0, 0, 0, 1, FRZ);
        v(0, 0, 0, 0, 0, 0, 0, 0, 1, FRZ);
        v(1, 0, 0, 0, 0, 0, 0, 0, 1, NRM);
        idle(2);

        foreach (vecs[k]) begin
            @(posedge clk);
            #1;
            reset              = vecs[k].rst;
            hz.id_rs1          = vecs[k].rs1;
            hz.id_rs2          = vecs[k].rs2;
            hz.id_use_rs1      = vecs[k].u1;
            hz.id_use_rs2      = vecs[k].u2;
            hz.ex_rd           = vecs[k].rd;
            hz.ex_mem_read     = vecs[k].mr;
            hz.ex_branch_taken = vecs[k].br;
            hz.mem_busy        = vecs[k].busy;

            e.ctrl   = vecs[k].ctrl;
            e.stall  = 4'(m_stall);
            e.flush  = 4'(m_flush);
            e.freeze = 4'(m_freeze);
            e.st     = m_st;
            e.to     = m_to;
            sb.push_back(e);

            if (vecs[k].rst) begin
                m_stall = 0; m_flush = 0; m_freeze = 0; m_len = 0; m_st = 0; m_to = 0;
            end else begin
                if (vecs[k].ctrl == LUS) m_stall = (m_stall + 1) % 16;
                if (vecs[k].ctrl == BRF) m_flush = (m_flush + 1) % 16;
                m_st = vecs[k].busy;
                if (vecs[k].busy) begin
                    m_freeze = (m_freeze + 1) % 16;
                    m_len = (m_len < TIMEOUT) ? m_len + 1 : TIMEOUT;
                    if (m_len == TIMEOUT) m_to = 1'b1;
                end else begin
                    m_len = 0;
                end
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
